pc_stack: RTL

Parametrised program counter with a hardware return-address stack. It generalises the 8-bit load/increment/reset PC: it adds configurable width, relative branches, and call/return with a DEPTH-entry LIFO. It sits at the fetch stage and drives the instruction-memory address each cycle from a registered `pcout`.

---
 rtl/pc_stack.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pc_stack.sv
// Fetch-stage program counter with load/branch/call/return and a LIFO return stack.
// Define PC_STACK_ERR_EN to enable sticky overflow/underflow flags and err_clr.
module pc_stack #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  localparam int             LW        = $clog2(DEPTH+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pcin,
  input  logic [WIDTH-1:0] offset,
  input  logic             incr,
  input  logic             load,
  input  logic             branch,
  input  logic             call,
  input  logic             ret,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pcout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic [1:0]       err
);

  localparam int             IW       = $clog2(DEPTH);
  localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);
  localparam logic [IW-1:0]  TOP_IDX  = IW'(DEPTH-1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [WIDTH-1:0] stk_q [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] top;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    wr_idx;
  logic             wr_en;
  logic             is_full;
  logic             is_empty;
  logic             ovf;
  logic             unf;

  logic do_load;
  logic do_br;
  logic do_call;
  logic do_ret;
  logic do_incr;

  assign pc_inc   = pc_q + WIDTH'(1);
  assign is_full  = (lvl_q == LVL_FULL);
  assign is_empty = (lvl_q == '0);
  assign rd_idx   = IW'(lvl_q - LW'(1));
  assign top      = stk_q[rd_idx];

  // Reduce the raw strobes to a one-hot command honouring priority.
  assign do_load = load;
  assign do_br   = branch & ~load;
  assign do_call = call & ~load & ~branch;
  assign do_ret  = ret & ~load & ~branch & ~call;
  assign do_incr = incr & ~(load | branch | call | ret);

  always_comb begin
    pc_d   = pc_q;
    lvl_d  = lvl_q;
    wr_en  = 1'b0;
    wr_idx = IW'(lvl_q);
    ovf    = 1'b0;
    unf    = 1'b0;
    unique case (1'b1)
      do_load: pc_d = pcin;
      do_br:   pc_d = pc_q + offset;
      do_call: begin
        if (!is_full) begin
          wr_en = 1'b1;
          lvl_d = lvl_q + LW'(1);
          pc_d  = pcin;
        end else begin
          ovf = 1'b1;
`ifndef PC_STACK_ERR_EN
          // Without error reporting, a full stack keeps the newest return.
          wr_en  = 1'b1;
          wr_idx = TOP_IDX;
          pc_d   = pcin;
`endif
        end
      end
      do_ret: begin
        if (!is_empty) begin
          pc_d  = top;
          lvl_d = lvl_q - LW'(1);
        end else begin
          unf = 1'b1;
        end
      end
      do_incr: pc_d = pc_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      lvl_q <= '0;
    end else begin
      pc_q  <= pc_d;
      lvl_q <= lvl_d;
    end
  end

  // Entries above level are don't-care, so the array needs no reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      stk_q[wr_idx] <= pc_inc;
    end
  end

`ifdef PC_STACK_ERR_EN
  logic [1:0] err_q, err_d;

  assign err_d = (err_clr ? 2'b00 : err_q) | {unf, ovf};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic [2:0] unused_err;
  assign unused_err = {err_clr, ovf, unf};
  assign err        = 2'b00;
`endif

  assign pcout = pc_q;
  assign level = lvl_q;
  assign full  = is_full;
  assign empty = is_empty;

endmodule
